// File: rtl/dsp_core.sv
// dsp_core: single-cycle 16-bit fixed-point DSP core with two data banks,
// an eight-entry register file, a 32-bit MAC accumulator and a halt state.
module dsp_core #(
  parameter int SRAM_ADDR_LEN = 15,
  parameter int REG_WORD_LEN  = 16,
  parameter int MEM_ADDR_LEN  = 16,
  parameter int INST_WORD_LEN = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [SRAM_ADDR_LEN-1:0] read_addr_1,
  input  logic [REG_WORD_LEN-1:0]  read_data_1,
  output logic [SRAM_ADDR_LEN-1:0] read_addr_2,
  input  logic [REG_WORD_LEN-1:0]  read_data_2,
  output logic [SRAM_ADDR_LEN-1:0] write_addr_2,
  output logic [REG_WORD_LEN-1:0]  write_data_2,
  output logic                     write_en_2,
  output logic [MEM_ADDR_LEN-1:0]  read_addr_i,
  input  logic [INST_WORD_LEN-1:0] read_data_i
);

  localparam int ACC_LEN  = 2 * REG_WORD_LEN;
  localparam int FRAC_LEN = REG_WORD_LEN - 1;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_LD1  = 5'd2;
  localparam logic [4:0] OP_LD2  = 5'd3;
  localparam logic [4:0] OP_ST2  = 5'd4;
  localparam logic [4:0] OP_ADD  = 5'd5;
  localparam logic [4:0] OP_SUB  = 5'd6;
  localparam logic [4:0] OP_ADDI = 5'd7;
  localparam logic [4:0] OP_MUL  = 5'd8;
  localparam logic [4:0] OP_MAC  = 5'd9;
  localparam logic [4:0] OP_MOVA = 5'd10;
  localparam logic [4:0] OP_CLRA = 5'd11;
  localparam logic [4:0] OP_JMP  = 5'd12;
  localparam logic [4:0] OP_BNZ  = 5'd13;
  localparam logic [4:0] OP_HALT = 5'd14;

  logic [MEM_ADDR_LEN-1:0]        pc_q, pc_d;
  logic [7:0][REG_WORD_LEN-1:0]   regs_q, regs_d;
  logic [ACC_LEN-1:0]             acc_q, acc_d;
  logic                           halt_q, halt_d;
  logic [SRAM_ADDR_LEN-1:0]       wr_addr_q, wr_addr_d;
  logic [REG_WORD_LEN-1:0]        wr_data_q, wr_data_d;
  logic                           wr_en_q, wr_en_d;

  logic [4:0]                     op_s;
  logic [2:0]                     rd_s;
  logic [2:0]                     rs1_s;
  logic [2:0]                     rs2_s;
  logic [15:0]                    imm_s;
  logic                           unused_rsvd_s;
  logic [REG_WORD_LEN-1:0]        rs1_val_s;
  logic [REG_WORD_LEN-1:0]        rs2_val_s;
  logic signed [ACC_LEN-1:0]      prod_s;
  logic [REG_WORD_LEN-1:0]        mul_res_s;
  logic [SRAM_ADDR_LEN-1:0]       ea_s;

  assign op_s          = read_data_i[31:27];
  assign rd_s          = read_data_i[26:24];
  assign rs1_s         = read_data_i[23:21];
  assign rs2_s         = read_data_i[20:18];
  assign imm_s         = read_data_i[15:0];
  assign unused_rsvd_s = ^read_data_i[17:16];

  assign rs1_val_s = regs_q[rs1_s];
  assign rs2_val_s = regs_q[rs2_s];

  // Q1.15 product; MUL keeps the renormalised middle word, MAC keeps all 32 bits.
  assign prod_s    = $signed(rs1_val_s) * $signed(rs2_val_s);
  assign mul_res_s = prod_s[FRAC_LEN +: REG_WORD_LEN];
  assign ea_s      = rs1_val_s[SRAM_ADDR_LEN-1:0] + imm_s[SRAM_ADDR_LEN-1:0];

  assign read_addr_i  = pc_q;
  assign read_addr_1  = ea_s;
  assign read_addr_2  = ea_s;
  assign write_addr_2 = wr_addr_q;
  assign write_data_2 = wr_data_q;
  assign write_en_2   = wr_en_q;

  // Execute the current instruction and compute all next-state values.
  always_comb begin
    pc_d      = pc_q;
    regs_d    = regs_q;
    acc_d     = acc_q;
    halt_d    = halt_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    if (!halt_q) begin
      pc_d = pc_q + MEM_ADDR_LEN'(1);
      case (op_s)
        OP_NOP:  regs_d = regs_q;
        OP_LDI:  regs_d[rd_s] = REG_WORD_LEN'(imm_s);
        OP_LD1:  regs_d[rd_s] = read_data_1;
        OP_LD2:  regs_d[rd_s] = read_data_2;
        OP_ST2: begin
          wr_addr_d = ea_s;
          wr_data_d = rs2_val_s;
          wr_en_d   = 1'b1;
        end
        OP_ADD:  regs_d[rd_s] = rs1_val_s + rs2_val_s;
        OP_SUB:  regs_d[rd_s] = rs1_val_s - rs2_val_s;
        OP_ADDI: regs_d[rd_s] = rs1_val_s + REG_WORD_LEN'(imm_s);
        OP_MUL:  regs_d[rd_s] = mul_res_s;
        OP_MAC:  acc_d = acc_q + prod_s;
        OP_MOVA: regs_d[rd_s] = acc_q[FRAC_LEN +: REG_WORD_LEN];
        OP_CLRA: acc_d = {ACC_LEN{1'b0}};
        OP_JMP:  pc_d = MEM_ADDR_LEN'(imm_s);
        OP_BNZ: begin
          if (rs1_val_s != {REG_WORD_LEN{1'b0}}) begin
            pc_d = MEM_ADDR_LEN'(imm_s);
          end else begin
            pc_d = pc_q + MEM_ADDR_LEN'(1);
          end
        end
        OP_HALT: begin
          halt_d = 1'b1;
          pc_d   = pc_q;
        end
        default: regs_d = regs_q;
      endcase
    end else begin
      pc_d = pc_q;
    end
  end

  // Architectural state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= {MEM_ADDR_LEN{1'b0}};
      regs_q    <= '0;
      acc_q     <= {ACC_LEN{1'b0}};
      halt_q    <= 1'b0;
      wr_addr_q <= {SRAM_ADDR_LEN{1'b0}};
      wr_data_q <= {REG_WORD_LEN{1'b0}};
      wr_en_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      regs_q    <= regs_d;
      acc_q     <= acc_d;
      halt_q    <= halt_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
    end
  end

endmodule

// File: tb/tb_dsp_core.sv
// Bench for dsp_core: small programs run from an instruction ROM model;
// bank II writes are scored against a queue of expected stores.
module tb_dsp_core;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_LD1  = 5'd2;
  localparam logic [4:0] OP_LD2  = 5'd3;
  localparam logic [4:0] OP_ST2  = 5'd4;
  localparam logic [4:0] OP_ADD  = 5'd5;
  localparam logic [4:0] OP_SUB  = 5'd6;
  localparam logic [4:0] OP_ADDI = 5'd7;
  localparam logic [4:0] OP_MUL  = 5'd8;
  localparam logic [4:0] OP_MAC  = 5'd9;
  localparam logic [4:0] OP_MOVA = 5'd10;
  localparam logic [4:0] OP_CLRA = 5'd11;
  localparam logic [4:0] OP_JMP  = 5'd12;
  localparam logic [4:0] OP_BNZ  = 5'd13;
  localparam logic [4:0] OP_HALT = 5'd14;

  typedef struct {
    logic [14:0] addr;
    logic [15:0] data;
  } wr_t;

  logic        clk;
  logic        rst;
  logic [14:0] read_addr_1;
  logic [15:0] read_data_1;
  logic [14:0] read_addr_2;
  logic [15:0] read_data_2;
  logic [14:0] write_addr_2;
  logic [15:0] write_data_2;
  logic        write_en_2;
  logic [15:0] read_addr_i;
  logic [31:0] read_data_i;

  logic [31:0] imem  [0:63];
  logic [15:0] bank1 [0:32767];
  logic [15:0] bank2 [0:32767];
  wr_t         exp_q [$];
  int          checks;
  int          passes;
  int          wr_count;

  dsp_core dut (
    .clk          (clk),
    .rst          (rst),
    .read_addr_1  (read_addr_1),
    .read_data_1  (read_data_1),
    .read_addr_2  (read_addr_2),
    .read_data_2  (read_data_2),
    .write_addr_2 (write_addr_2),
    .write_data_2 (write_data_2),
    .write_en_2   (write_en_2),
    .read_addr_i  (read_addr_i),
    .read_data_i  (read_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous-read memories; bank II shows a pending write through to its read port.
  assign read_data_i = imem[read_addr_i[5:0]];
  assign read_data_1 = bank1[read_addr_1];
  assign read_data_2 = (write_en_2 && (write_addr_2 == read_addr_2)) ? write_data_2 : bank2[read_addr_2];

  always @(posedge clk) begin
    if (write_en_2) bank2[write_addr_2] <= write_data_2;
  end

  // Scoreboard: every observed bank II write must match the oldest expected store.
  always @(negedge clk) begin
    if (write_en_2 === 1'b1) begin
      wr_t e;
      wr_count = wr_count + 1;
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", write_addr_2, write_data_2);
      end else begin
        e = exp_q.pop_front();
        if ({write_addr_2, write_data_2} !== {e.addr, e.data})
          $display("FAIL store: got addr=%h data=%h, required addr=%h data=%h",
                   write_addr_2, write_data_2, e.addr, e.data);
        else
          passes = passes + 1;
      end
    end
  end

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2,
                                      input logic [15:0] imm);
    return {op, rd, rs1, rs2, 2'b00, imm};
  endfunction

  task automatic expect_wr(input logic [14:0] a, input logic [15:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_0000;
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check_drained(input string name);
    checks = checks + 1;
    if (exp_q.size() != 0)
      $display("FAIL %s_drain: %0d stores still expected, required 0", name, exp_q.size());
    else
      passes = passes + 1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    clear_prog();
    imem[0] = enc(OP_NOP, 3'd0, 3'd0, 3'd0, 16'h0123);
    do_reset();
    checks = checks + 1;
    if (read_addr_i !== 16'h0000) $display("FAIL reset_pc: got %h, required 0000", read_addr_i);
    else passes = passes + 1;
    checks = checks + 1;
    if ({write_en_2, write_addr_2, write_data_2} !== 32'h0)
      $display("FAIL reset_wr: got en=%b addr=%h data=%h, required all 0", write_en_2, write_addr_2, write_data_2);
    else passes = passes + 1;
    checks = checks + 1;
    if ({read_addr_1, read_addr_2} !== {15'h0123, 15'h0123})
      $display("FAIL reset_ea: got %h/%h, required 0123/0123", read_addr_1, read_addr_2);
    else passes = passes + 1;
  endtask

  task automatic test_ld_st_halt();
    int wr0;
    clear_prog();
    bank1[0] = 16'd25;
    imem[0] = enc(OP_LD1, 3'd0, 3'd0, 3'd0, 16'd0);
    imem[1] = enc(OP_ST2, 3'd0, 3'd0, 3'd0, 16'd1);
    imem[2] = enc(OP_HALT, 3'd0, 3'd0, 3'd0, 16'd0);
    do_reset();
    wr0 = wr_count;
    expect_wr(15'd26, 16'd25);
    run_cycles(6);
    checks = checks + 1;
    if (read_addr_i !== 16'd2) $display("FAIL halt_pc: got %0d, required 2", read_addr_i);
    else passes = passes + 1;
    checks = checks + 1;
    if (wr_count - wr0 != 1) $display("FAIL halt_wr_count: got %0d, required 1", wr_count - wr0);
    else passes = passes + 1;
    check_drained("ld_st_halt");
  endtask

  task automatic test_mul_mac();
    clear_prog();
    imem[0]  = enc(OP_LDI,  3'd1, 3'd0, 3'd0, 16'h4000);
    imem[1]  = enc(OP_LDI,  3'd2, 3'd0, 3'd0, 16'h4000);
    imem[2]  = enc(OP_MUL,  3'd3, 3'd1, 3'd2, 16'h0000);
    imem[3]  = enc(OP_MAC,  3'd0, 3'd1, 3'd2, 16'h0000);
    imem[4]  = enc(OP_MAC,  3'd0, 3'd1, 3'd2, 16'h0000);
    imem[5]  = enc(OP_MOVA, 3'd4, 3'd0, 3'd0, 16'h0000);
    imem[6]  = enc(OP_ST2,  3'd0, 3'd0, 3'd3, 16'h0010);
    imem[7]  = enc(OP_ST2,  3'd0, 3'd0, 3'd4, 16'h0011);
    imem[8]  = enc(OP_LDI,  3'd6, 3'd0, 3'd0, 16'hC000);
    imem[9]  = enc(OP_MUL,  3'd7, 3'd6, 3'd1, 16'h0000);
    imem[10] = enc(OP_CLRA, 3'd0, 3'd0, 3'd0, 16'h0000);
    imem[11] = enc(OP_MOVA, 3'd5, 3'd0, 3'd0, 16'h0000);
    imem[12] = enc(OP_ST2,  3'd0, 3'd0, 3'd7, 16'h0012);
    imem[13] = enc(OP_ST2,  3'd0, 3'd0, 3'd5, 16'h0013);
    imem[14] = enc(OP_HALT, 3'd0, 3'd0, 3'd0, 16'h0000);
    do_reset();
    expect_wr(15'h0010, 16'h2000);
    expect_wr(15'h0011, 16'h4000);
    expect_wr(15'h0012, 16'hE000);
    expect_wr(15'h0013, 16'h0000);
    run_cycles(20);
    check_drained("mul_mac");
  endtask

  task automatic test_wrap();
    clear_prog();
    imem[0] = enc(OP_LDI,  3'd1, 3'd0, 3'd0, 16'h7FFF);
    imem[1] = enc(OP_ADDI, 3'd1, 3'd1, 3'd0, 16'h0001);
    imem[2] = enc(OP_SUB,  3'd2, 3'd0, 3'd1, 16'h0000);
    imem[3] = enc(OP_ADD,  3'd3, 3'd1, 3'd1, 16'h0000);
    imem[4] = enc(OP_LDI,  3'd4, 3'd0, 3'd0, 16'h7FFF);
    imem[5] = enc(OP_ST2,  3'd0, 3'd0, 3'd1, 16'h0005);
    imem[6] = enc(OP_ST2,  3'd0, 3'd0, 3'd2, 16'h0006);
    imem[7] = enc(OP_ST2,  3'd0, 3'd4, 3'd1, 16'h0002);
    imem[8] = enc(OP_ST2,  3'd0, 3'd0, 3'd3, 16'h0008);
    imem[9] = enc(OP_HALT, 3'd0, 3'd0, 3'd0, 16'h0000);
    do_reset();
    expect_wr(15'h0005, 16'h8000);
    expect_wr(15'h0006, 16'h8000);
    expect_wr(15'h0001, 16'h8000);
    expect_wr(15'h0008, 16'h0000);
    run_cycles(14);
    check_drained("wrap");
  endtask

  task automatic test_loop();
    logic [15:0] exp_pc [9];
    clear_prog();
    exp_pc = '{16'd1, 16'd2, 16'd1, 16'd2, 16'd1, 16'd2, 16'd3, 16'd4, 16'd4};
    imem[0] = enc(OP_LDI,  3'd1, 3'd0, 3'd0, 16'd3);
    imem[1] = enc(OP_ADDI, 3'd1, 3'd1, 3'd0, 16'hFFFF);
    imem[2] = enc(OP_BNZ,  3'd0, 3'd1, 3'd0, 16'd1);
    imem[3] = enc(OP_ST2,  3'd0, 3'd0, 3'd1, 16'h0007);
    imem[4] = enc(OP_HALT, 3'd0, 3'd0, 3'd0, 16'd0);
    do_reset();
    expect_wr(15'h0007, 16'h0000);
    for (int i = 0; i < 9; i++) begin
      run_cycles(1);
      checks = checks + 1;
      if (read_addr_i !== exp_pc[i])
        $display("FAIL loop_pc[%0d]: got %0d, required %0d", i, read_addr_i, exp_pc[i]);
      else passes = passes + 1;
    end
    check_drained("loop");
  endtask

  task automatic test_back_to_back();
    clear_prog();
    bank1[15'h0022] = 16'hBEEF;
    bank2[15'h0020] = 16'hDEAD;
    imem[0] = enc(OP_LDI,  3'd1, 3'd0, 3'd0, 16'h1234);
    imem[1] = enc(OP_ST2,  3'd0, 3'd0, 3'd1, 16'h0020);
    imem[2] = enc(OP_LD2,  3'd2, 3'd0, 3'd0, 16'h0020);
    imem[3] = enc(OP_ST2,  3'd0, 3'd0, 3'd2, 16'h0021);
    imem[4] = enc(OP_LD1,  3'd3, 3'd0, 3'd0, 16'h0022);
    imem[5] = enc(OP_ST2,  3'd0, 3'd0, 3'd3, 16'h0022);
    imem[6] = enc(OP_HALT, 3'd0, 3'd0, 3'd0, 16'h0000);
    do_reset();
    expect_wr(15'h0020, 16'h1234);
    expect_wr(15'h0021, 16'h1234);
    expect_wr(15'h0022, 16'hBEEF);
    run_cycles(10);
    check_drained("back_to_back");
  endtask

  task automatic test_jump();
    clear_prog();
    imem[0] = enc(OP_LDI, 3'd1, 3'd0, 3'd0, 16'd9);
    imem[1] = enc(OP_JMP, 3'd0, 3'd0, 3'd0, 16'd3);
    imem[2] = enc(OP_ST2, 3'd0, 3'd0, 3'd1, 16'h0060);
    imem[3] = enc(OP_ST2, 3'd0, 3'd0, 3'd1, 16'h0061);
    imem[4] = enc(OP_JMP, 3'd0, 3'd0, 3'd0, 16'd4);
    do_reset();
    expect_wr(15'h0061, 16'd9);
    run_cycles(8);
    checks = checks + 1;
    if (read_addr_i !== 16'd4 || write_en_2 !== 1'b0)
      $display("FAIL jump_self: got pc=%0d en=%b, required pc=4 en=0", read_addr_i, write_en_2);
    else passes = passes + 1;
    check_drained("jump");
  endtask

  task automatic test_rst_mid();
    clear_prog();
    imem[0] = enc(OP_ST2,  3'd0, 3'd1, 3'd1, 16'h0040);
    imem[1] = enc(OP_LDI,  3'd1, 3'd0, 3'd0, 16'h4000);
    imem[2] = enc(OP_MAC,  3'd0, 3'd1, 3'd1, 16'h0000);
    imem[3] = enc(OP_ST2,  3'd0, 3'd0, 3'd1, 16'h0030);
    imem[4] = enc(OP_MOVA, 3'd2, 3'd0, 3'd0, 16'h0000);
    imem[5] = enc(OP_ST2,  3'd0, 3'd0, 3'd2, 16'h0031);
    imem[6] = enc(OP_HALT, 3'd0, 3'd0, 3'd0, 16'h0000);
    do_reset();
    expect_wr(15'h0040, 16'h0000);
    run_cycles(3);
    checks = checks + 1;
    if (read_addr_i !== 16'd3) $display("FAIL rst_mid_pre_pc: got %0d, required 3", read_addr_i);
    else passes = passes + 1;
    rst = 1'b1;
    run_cycles(1);
    checks = checks + 1;
    if ({read_addr_i, write_en_2, write_addr_2, write_data_2} !== 48'h0)
      $display("FAIL rst_mid_state: got pc=%h en=%b addr=%h data=%h, required all 0",
               read_addr_i, write_en_2, write_addr_2, write_data_2);
    else passes = passes + 1;
    rst = 1'b0;
    expect_wr(15'h0040, 16'h0000);
    expect_wr(15'h0030, 16'h4000);
    expect_wr(15'h0031, 16'h2000);
    run_cycles(10);
    check_drained("rst_mid");
  endtask

  task automatic test_undef();
    clear_prog();
    imem[0] = enc(5'h1F,   3'd1, 3'd0, 3'd0, 16'h7777);
    imem[1] = enc(5'd15,   3'd2, 3'd0, 3'd0, 16'h5555);
    imem[2] = enc(OP_ST2,  3'd0, 3'd0, 3'd1, 16'h0050);
    imem[3] = enc(OP_ST2,  3'd0, 3'd0, 3'd2, 16'h0051);
    imem[4] = enc(OP_HALT, 3'd0, 3'd0, 3'd0, 16'h0000);
    do_reset();
    run_cycles(1);
    checks = checks + 1;
    if (read_addr_i !== 16'd1 || write_en_2 !== 1'b0)
      $display("FAIL undef_step: got pc=%0d en=%b, required pc=1 en=0", read_addr_i, write_en_2);
    else passes = passes + 1;
    expect_wr(15'h0050, 16'h0000);
    expect_wr(15'h0051, 16'h0000);
    run_cycles(6);
    check_drained("undef");
  endtask

  initial begin
    checks   = 0;
    passes   = 0;
    wr_count = 0;
    rst      = 1'b1;
    for (int i = 0; i < 32768; i++) begin
      bank1[i] = 16'h0000;
      bank2[i] = 16'h0000;
    end
    test_reset();
    test_ld_st_halt();
    test_mul_mac();
    test_wrap();
    test_loop();
    test_back_to_back();
    test_jump();
    test_rst_mid();
    test_undef();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
